// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 3-digit timer display: snapshots digits per
// frame, drives a shared BCD decoder and produces guarded, blanked, blinkable enables.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 100,
    parameter int unsigned LZB          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min,
    input  logic       blink_en,
    output logic [3:0] dec_bcd,
    input  logic [6:0] dec_segs,
    output logic [6:0] seg,
    output logic [2:0] dig_en,
    output logic       frame_tick
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_GUARD  = PW'(GUARD);
    localparam logic [BW-1:0] B_LAST   = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_DASH = 7'b0000001;
    localparam logic [1:0]    SLOT_ONES = 2'd0;
    localparam logic [1:0]    SLOT_TENS = 2'd1;
    localparam logic [1:0]    SLOT_MIN  = 2'd2;

    logic [PW-1:0] p;
    logic [1:0]    slot;
    logic [3:0]    sh_ones;
    logic [3:0]    sh_tens;
    logic [3:0]    sh_min;
    logic          sh_blink;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic          p_end;
    logic          frame_end;
    logic [PW-1:0] p_nxt;
    logic [1:0]    slot_nxt;
    logic [3:0]    sel_digit;
    logic [3:0]    dec_nxt;
    logic          lz_min;
    logic          lz_tens;
    logic          slot_on;
    logic          dark;
    logic [2:0]    dig_en_nxt;
    logic          frame_tick_nxt;
    logic [6:0]    seg_nxt;

    // Scan position for the next cycle
    always_comb begin
        p_end     = (p == P_LAST);
        frame_end = p_end && (slot == SLOT_MIN);
        p_nxt     = p_end ? '0 : p + PW'(1);
        slot_nxt  = slot;
        if (p_end) begin
            slot_nxt = (slot == SLOT_MIN) ? SLOT_ONES : slot + 2'd1;
        end
    end

    // Decoder input follows the slot being entered; at frame end it takes the fresh snapshot
    always_comb begin
        case (slot_nxt)
            SLOT_TENS: sel_digit = sh_tens;
            SLOT_MIN:  sel_digit = sh_min;
            default:   sel_digit = sh_ones;
        endcase
        dec_nxt = frame_end ? sec_ones : sel_digit;
    end

    // Enables are only ever raised at p >= GUARD, where the shadow cannot change this edge
    always_comb begin
        lz_min  = (LZB != 0) && (sh_min == 4'd0);
        lz_tens = lz_min && (sh_tens == 4'd0);
        case (slot_nxt)
            SLOT_TENS: slot_on = !lz_tens;
            SLOT_MIN:  slot_on = !lz_min;
            default:   slot_on = 1'b1;
        endcase
        dark       = sh_blink && blink_phase;
        dig_en_nxt = '0;
        if ((p_nxt >= P_GUARD) && slot_on && !dark) begin
            dig_en_nxt = 3'b001 << slot_nxt;
        end
        frame_tick_nxt = (slot_nxt == SLOT_MIN) && (p_nxt == P_LAST);
        seg_nxt        = (dec_bcd > 4'd9) ? SEG_DASH : dec_segs;
    end

    // Prescaler, slot counter and frame snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p        <= '0;
            slot     <= SLOT_ONES;
            sh_ones  <= '0;
            sh_tens  <= '0;
            sh_min   <= '0;
            sh_blink <= 1'b0;
        end else begin
            p    <= p_nxt;
            slot <= slot_nxt;
            if (frame_end) begin
                sh_ones  <= sec_ones;
                sh_tens  <= sec_tens;
                sh_min   <= min;
                sh_blink <= blink_en;
            end
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames while blinking; clears otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!sh_blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == B_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_bcd    <= '0;
            seg        <= '0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            dec_bcd    <= dec_nxt;
            seg        <= seg_nxt;
            dig_en     <= dig_en_nxt;
            frame_tick <= frame_tick_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed and random digit/blink stimulus compared every
// cycle against a frame-level model of what the display should show.
module tb_display_scan_ctrl;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned GUARD        = 1;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int unsigned LZB          = 1;
    localparam int unsigned FRAME        = 3 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec_ones = '0;
    logic [3:0] sec_tens = '0;
    logic [3:0] min = '0;
    logic       blink_en = 1'b0;
    logic [3:0] dec_bcd;
    logic [6:0] dec_segs;
    logic [6:0] seg;
    logic [2:0] dig_en;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    // Model: cycle index since reset release and the digits shown in the current frame
    int t;
    int m_ones, m_tens, m_min, m_blink, run;

    display_scan_ctrl #(
        .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES), .LZB(LZB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sec_ones(sec_ones), .sec_tens(sec_tens), .min(min),
        .blink_en(blink_en), .dec_bcd(dec_bcd), .dec_segs(dec_segs), .seg(seg),
        .dig_en(dig_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    // External decoder stand-in: undefined output for non-BCD codes
    always_comb begin
        if (dec_bcd <= 4'd9) dec_segs = seg_of(int'(dec_bcd));
        else                 dec_segs = 7'bxxxxxxx;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int slot, p, d;
        logic on, dark;
        logic [31:0] exp_en;
        slot = (t / SCAN_DIV) % 3;
        p    = t % SCAN_DIV;
        d    = (slot == 0) ? m_ones : (slot == 1) ? m_tens : m_min;
        on   = 1'b1;
        if (LZB != 0 && slot == 2 && m_min == 0) on = 1'b0;
        if (LZB != 0 && slot == 1 && m_min == 0 && m_tens == 0) on = 1'b0;
        dark   = (m_blink != 0) && (((run - 1) / BLINK_FRAMES) % 2 == 1);
        exp_en = (p >= GUARD && on && !dark) ? (32'd1 << slot) : 32'd0;
        chk("dig_en", 32'(dig_en), exp_en);
        chk("frame_tick", 32'(frame_tick), 32'(slot == 2 && p == SCAN_DIV - 1));
        chk("dec_bcd", 32'(dec_bcd), 32'(d));
        if (p >= 1) chk("seg", 32'(seg), 32'(seg_of(d)));
    endtask

    // One clock: inputs present at a frame-end edge become the next frame's content
    task automatic step();
        logic boundary;
        int n_ones, n_tens, n_min, n_blink;
        boundary = (t % FRAME == FRAME - 1);
        n_ones = int'(sec_ones);
        n_tens = int'(sec_tens);
        n_min  = int'(min);
        n_blink = int'(blink_en);
        @(posedge clk);
        #1;
        t++;
        if (boundary) begin
            m_ones = n_ones;
            m_tens = n_tens;
            m_min  = n_min;
            m_blink = n_blink;
            run = (n_blink != 0) ? run + 1 : 0;
        end
        check_cycle();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input int o, input int tn, input int mn, input logic b);
        sec_ones = 4'(o);
        sec_tens = 4'(tn);
        min      = 4'(mn);
        blink_en = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0; m_ones = 0; m_tens = 0; m_min = 0; m_blink = 0; run = 0;
        #1;
        check_cycle();
    endtask

    initial begin
        // Reset frame shows the zero snapshot even though 3:47 is already applied
        set_in(7, 4, 3, 1'b0);
        do_reset();
        run_cycles(3 * FRAME);

        // Leading-zero blanking: only ones, then ones + tens
        set_in(5, 0, 0, 1'b0);
        run_cycles(2 * FRAME);
        set_in(8, 3, 0, 1'b0);
        run_cycles(2 * FRAME);

        // Invalid digits show a dash and are never blanked
        set_in(12, 4, 3, 1'b0);
        run_cycles(2 * FRAME);
        set_in(2, 15, 0, 1'b0);
        run_cycles(2 * FRAME);
        set_in(0, 0, 10, 1'b0);
        run_cycles(2 * FRAME);

        // Tearing: change sec_ones during slot 1; shows next frame
        set_in(7, 4, 3, 1'b0);
        run_cycles(2 * FRAME);
        while (t % FRAME != SCAN_DIV + 1) step();
        sec_ones = 4'd2;
        run_cycles(2 * FRAME);

        // Blink: 2 visible frames, 2 dark, repeating; then release
        blink_en = 1'b1;
        run_cycles(9 * FRAME);
        blink_en = 1'b0;
        run_cycles(3 * FRAME);

        // Random digits and blink, changed at arbitrary cycles within frames
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: sec_ones = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    1: sec_tens = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    default: min = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
            step();
        end

        // Asynchronous reset mid-slot clears outputs before the next edge
        set_in(7, 4, 3, 1'b0);
        run_cycles(2 * FRAME + 1);
        while (t % FRAME != 2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_dec_bcd", 32'(dec_bcd), 32'd0);
        do_reset();
        run_cycles(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
